// File: rtl/piso_pkg.sv
// Shared types and helpers for the parametrised PISO serializer.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_e;

  function automatic int frame_len(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Saturating frame-bit counter: counts 0..MAX, cleared on every load.
module piso_bit_counter #(
  parameter int MAX = 7,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_max
);

  assign at_max = (count == CW'(MAX));

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load and gapless frames.
// Define PISO_PARITY_EN to append an even-parity bit as the final frame bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_en,
  output logic             serial_o,
  output logic             serial_valid,
  output logic             last_o,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = frame_len(WIDTH, 1'b1);
`else
  localparam int FRAME_LEN = frame_len(WIDTH, 1'b0);
`endif
  localparam int CNT_W = $clog2(WIDTH + 1);

  piso_state_e          state;
  logic [FRAME_LEN-2:0] rest;     // frame bits still to be presented after serial_o
  logic [WIDTH-1:0]     ordered;
  logic [FRAME_LEN-1:0] frame;
  logic [CNT_W-1:0]     count;
  logic                 at_max;
  logic                 accept;
  logic                 advance;
  logic                 frame_end;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ordered[i] = LSB_FIRST ? data_i[i] : data_i[WIDTH-1-i];
    end
  end

`ifdef PISO_PARITY_EN
  assign frame = {^data_i, ordered};
`else
  assign frame = ordered;
`endif

  assign load_ready = (state == IDLE) || ((state == SHIFT) && at_max && shift_en);
  assign accept     = load_valid && load_ready;
  assign advance    = (state == SHIFT) && shift_en && !at_max;
  assign frame_end  = (state == SHIFT) && shift_en && at_max && !accept;
  assign busy       = serial_valid;

  piso_bit_counter #(
    .MAX (FRAME_LEN - 1),
    .CW  (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept || frame_end),
    .inc    (advance),
    .count  (count),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rest         <= {(FRAME_LEN-1){IDLE_LEVEL}};
      serial_o     <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      last_o       <= 1'b0;
    end else if (accept) begin
      state        <= SHIFT;
      rest         <= frame[FRAME_LEN-1:1];
      serial_o     <= frame[0];
      serial_valid <= 1'b1;
      last_o       <= 1'b0;
    end else if (advance) begin
      rest         <= (FRAME_LEN-1)'({IDLE_LEVEL, rest} >> 1);
      serial_o     <= rest[0];
      last_o       <= (count == CNT_W'(FRAME_LEN - 2));
    end else if (frame_end) begin
      state        <= IDLE;
      rest         <= {(FRAME_LEN-1){IDLE_LEVEL}};
      serial_o     <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      last_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB- and MSB-first instances share one stimulus
// stream and are checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             shift_en;
  logic [WIDTH-1:0] data;
  logic             rdy_l, so_l, sv_l, last_l, busy_l;
  logic             rdy_m, so_m, sv_m, last_m, busy_m;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: one frame in flight, index of the bit currently shown.
  bit               m_active = 1'b0;
  int               m_idx    = 0;
  logic [WIDTH-1:0] m_data   = '0;

  bit log_l[$];
  bit log_m[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_l),
    .data_i(data), .shift_en(shift_en), .serial_o(so_l), .serial_valid(sv_l),
    .last_o(last_l), .busy(busy_l)
  );

  piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_m),
    .data_i(data), .shift_en(shift_en), .serial_o(so_m), .serial_valid(sv_m),
    .last_o(last_m), .busy(busy_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input bit lsb);
    if (m_idx >= WIDTH) return ^m_data;
    return lsb ? m_data[m_idx] : m_data[WIDTH-1-m_idx];
  endfunction

  function automatic bit m_ready();
    return !m_active || ((m_idx == FL - 1) && (shift_en === 1'b1));
  endfunction

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_idx    = 0;
    end else if (load_valid && m_ready()) begin
      m_active = 1'b1;
      m_idx    = 0;
      m_data   = data;
    end else if (m_active && shift_en) begin
      if (m_idx == FL - 1) m_active = 1'b0;
      else                 m_idx++;
    end
  end

  always @(negedge clk) begin
    #3;
    if (chk_en) begin
      check("lsb.serial_o",     32'(so_l),   32'(m_active ? exp_bit(1'b1) : 1'b1));
      check("lsb.serial_valid", 32'(sv_l),   32'(m_active));
      check("lsb.last_o",       32'(last_l), 32'(m_active && m_idx == FL - 1));
      check("lsb.busy",         32'(busy_l), 32'(m_active));
      check("lsb.load_ready",   32'(rdy_l),  32'(m_ready()));
      check("msb.serial_o",     32'(so_m),   32'(m_active ? exp_bit(1'b0) : 1'b1));
      check("msb.serial_valid", 32'(sv_m),   32'(m_active));
      check("msb.last_o",       32'(last_m), 32'(m_active && m_idx == FL - 1));
      check("msb.load_ready",   32'(rdy_m),  32'(m_ready()));
      if (sv_l) log_l.push_back(so_l);
      if (sv_m) log_m.push_back(so_m);
    end
  end

  task automatic tick(input bit rn, input bit lv, input bit se, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst_n      = rn;
    load_valid = lv;
    shift_en   = se;
    data       = d;
  endtask

  task automatic settle_and_clear();
    #4;
    log_l.delete();
    log_m.delete();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d);
    tick(1'b1, 1'b1, 1'b1, d);
    repeat (FL) tick(1'b1, 1'b0, 1'b1, '0);
    repeat (2) tick(1'b1, 1'b0, 1'b1, '0);
    #4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; shift_en = 1'b0; data = '0;
    tick(1'b0, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);

    // Reset then idle with no load
    repeat (8) tick(1'b1, 1'b0, 1'b1, '0);
    #4;
    check("reset.serial_o",   32'(so_l),  32'd1);
    check("reset.valid",      32'(sv_l),  32'd0);
    check("reset.load_ready", 32'(rdy_l), 32'd1);
    settle_and_clear();

`ifndef PISO_PARITY_EN
    send_frame(8'h55);
    check("lsb55.stream", pack(log_l), 32'h55);
    check("lsb55.length", 32'(log_l.size()), 32'd8);
    check("msb55.stream", pack(log_m), 32'hAA);
    settle_and_clear();

    send_frame(8'hA3);
    check("lsbA3.stream", pack(log_l), 32'hA3);
    check("msbA3.stream", pack(log_m), 32'hC5);
    settle_and_clear();

    // Back-to-back: 0F offered throughout, only taken at the last bit
    tick(1'b1, 1'b1, 1'b1, 8'hF0);
    repeat (FL) tick(1'b1, 1'b1, 1'b1, 8'h0F);
    repeat (FL + 2) tick(1'b1, 1'b0, 1'b1, '0);
    #4;
    check("b2b.lsb_stream", pack(log_l), 32'h0FF0);
    check("b2b.length",     32'(log_l.size()), 32'd16);
    check("b2b.msb_stream", pack(log_m), 32'hF00F);
    settle_and_clear();

    // Stall three cycles while bit 2 is shown
    tick(1'b1, 1'b1, 1'b1, 8'hC5);
    repeat (2) tick(1'b1, 1'b0, 1'b1, '0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, '0);
    repeat (FL - 2) tick(1'b1, 1'b0, 1'b1, '0);
    repeat (2) tick(1'b1, 1'b0, 1'b1, '0);
    #4;
    check("stall.lsb_stream", pack(log_l), 32'h63D);
    check("stall.length",     32'(log_l.size()), 32'd11);
    check("stall.msb_stream", pack(log_m), 32'h503);
    settle_and_clear();
`else
    send_frame(8'h07);
    check("par07.lsb_stream", pack(log_l), 32'h107);
    check("par07.length",     32'(log_l.size()), 32'd9);
    check("par07.msb_stream", pack(log_m), 32'h1E0);
    settle_and_clear();

    send_frame(8'h03);
    check("par03.lsb_stream", pack(log_l), 32'h003);
    check("par03.length",     32'(log_l.size()), 32'd9);
    check("par03.msb_stream", pack(log_m), 32'h0C0);
    settle_and_clear();
`endif

    // Abort mid-frame with reset while bit 5 is shown
    tick(1'b1, 1'b1, 1'b1, 8'hC5);
    repeat (5) tick(1'b1, 1'b0, 1'b1, '0);
    tick(1'b0, 1'b0, 1'b1, '0);
    tick(1'b1, 1'b0, 1'b1, '0);
    #4;
    check("abort.valid",      32'(sv_l),  32'd0);
    check("abort.serial_o",   32'(so_l),  32'd1);
    check("abort.last_o",     32'(last_l), 32'd0);
    check("abort.load_ready", 32'(rdy_l), 32'd1);

    // Randomised traffic with stalls, back-to-back loads and rare resets
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 99) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           WIDTH'($urandom));
    end
    repeat (FL + 6) tick(1'b1, 1'b0, 1'b1, '0);
    #4;
    check("drain.valid", 32'(sv_l), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
